// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter, LSB first, with load handshake and hold stall
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             Ld_En,
    input  logic [WIDTH-1:0] D,
    input  logic             Hold,
    output logic             Ready,
    output logic             Out,
    output logic             Out_Vld,
    output logic             Done,
    output logic             Busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             last;

    // Out is the low bit of the shift register; it drains to zero after the last transfer,
    // which gives the idle-low line for free. Valid is the SEND state gated by the stall.
    always_comb begin
        last    = (state == SEND) && (cnt == CW'(WIDTH - 1)) && !Hold;
        Busy    = (state == SEND);
        Out     = sr[0];
        Out_Vld = (state == SEND) && !Hold;
        Done    = last;
        Ready   = (state == IDLE) || last;
    end

    // Acceptance reloads the word and restarts the count; a transfer shifts and counts on.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else if (Ld_En && Ready) begin
            state <= SEND;
            sr    <= D;
            cnt   <= '0;
        end else if (state == SEND && !Hold) begin
            sr    <= sr >> 1;
            cnt   <= last ? '0 : cnt + CW'(1);
            state <= last ? IDLE : SEND;
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed and random checks of piso_tx against a bit-queue model
module tb_piso_tx;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR, Ld_En, Hold;
    logic [W-1:0] D;
    logic         Ready, Out, Out_Vld, Done, Busy;
    logic [W-1:0] rx = '0;

    int total = 0;
    int bad   = 0;

    bit           q[$];
    logic [W-1:0] words[$];

    piso_tx #(.WIDTH(W)) dut (
        .CLK(CLK), .CLR(CLR), .Ld_En(Ld_En), .D(D), .Hold(Hold),
        .Ready(Ready), .Out(Out), .Out_Vld(Out_Vld), .Done(Done), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    // receiver: shift_rotate style, new bit enters at the MSB so LSB-first words land in order
    always @(posedge CLK) if (Out_Vld) rx <= {Out, rx[W-1:1]};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic c, input logic l, input logic [W-1:0] d, input logic h);
        logic busy_e, vld_e, out_e, done_e, rdy_e;
        logic [W-1:0] w;
        CLR = c; Ld_En = l; D = d; Hold = h;
        #3;
        busy_e = q.size() > 0;
        vld_e  = busy_e && !h;
        out_e  = busy_e ? q[0] : 1'b0;
        done_e = vld_e && q.size() == 1;
        rdy_e  = !busy_e || done_e;
        chk("busy",  {7'b0, Busy},    {7'b0, busy_e});
        chk("vld",   {7'b0, Out_Vld}, {7'b0, vld_e});
        chk("out",   {7'b0, Out},     {7'b0, out_e});
        chk("done",  {7'b0, Done},    {7'b0, done_e});
        chk("ready", {7'b0, Ready},   {7'b0, rdy_e});
        @(posedge CLK);
        #1;
        if (c) begin
            q.delete();
            words.delete();
        end else begin
            if (vld_e) void'(q.pop_front());
            if (done_e) begin
                w = words.pop_front();
                chk("rx", {4'b0, rx}, {4'b0, w});
            end
            if (l && rdy_e) begin
                for (int i = 0; i < W; i++) q.push_back(d[i]);
                words.push_back(d);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        CLR = 1'b1; Ld_En = 1'b0; D = '0; Hold = 1'b0;
        @(posedge CLK);
        #1;
        // reset wins over a simultaneous load
        step(1'b1, 1'b1, 4'b1111, 1'b0);
        idle(1);
        // single word
        step(1'b0, 1'b1, 4'b1101, 1'b0);
        idle(5);
        // back-to-back with load held high across the boundary
        step(1'b0, 1'b1, 4'b0011, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1010, 1'b0);
        idle(5);
        // two-cycle hold after the second bit
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        idle(2);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        idle(3);
        // load while busy is ignored
        step(1'b0, 1'b1, 4'b1001, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 4'b0111, 1'b0);
        idle(4);
        // mid-frame reset, then a clean word
        step(1'b0, 1'b1, 4'b1011, 1'b0);
        idle(2);
        step(1'b1, 1'b0, '0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 4'b0101, 1'b0);
        idle(5);
        // random traffic
        for (int i = 0; i < 500; i++)
            step($urandom_range(49) == 0, $urandom_range(1) == 1, W'($urandom), $urandom_range(3) == 0);
        idle(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
